dma_lint_arbiter: RTL and testbench
===================================

// Module: dma_lint_arbiter
// PURPOSE
//  Downstream of the DMA channels. Merges N_CH channel LINT master ports onto one shared LINT master port.
//  Round-robin arbitration; the request is locked until granted; an in-order ID FIFO routes rvalid/rdata back.
//  The 4-channel top uses two instances: one for all src ports, one for all dst ports.
// PARAMETERS
//  N_CH     4   number of channel ports
//  ADDR_WD  32  address width
//  DATA_WD  32  data width
//  BE_WD    DATA_WD/8  byte-enable width
//  MAX_OUT  4   max outstanding granted-but-unanswered transactions (power of 2, >=2)
// PORTS
//  clk_i         in   1              clock
//  rstn_i        in   1              async active-low reset
//  ch_req_i      in   N_CH           per-channel request
//  ch_we_i       in   N_CH           per-channel write enable
//  ch_addr_i     in   N_CH*ADDR_WD   packed, channel k at [k*ADDR_WD +: ADDR_WD]
//  ch_wdata_i    in   N_CH*DATA_WD   packed write data
//  ch_be_i       in   N_CH*BE_WD     packed byte enables
//  ch_gnt_o      out  N_CH           one-hot grant
//  ch_rvalid_o   out  N_CH           one-hot response valid
//  ch_rdata_o    out  DATA_WD        response data, broadcast; qualified by ch_rvalid_o
//  lint_req_o    out  1              shared-port request
//  lint_we_o     out  1              shared-port write enable
//  lint_addr_o   out  ADDR_WD        shared-port address
//  lint_wdata_o  out  DATA_WD        shared-port write data
//  lint_be_o     out  BE_WD          shared-port byte enables
//  lint_gnt_i    in   1              slave grant
//  lint_rdata_i  in   DATA_WD        slave response data
//  lint_rvalid_i in   1              slave response valid; responses return in order
//  outstanding_o out  $clog2(MAX_OUT)+1  current FIFO occupancy
//  err_o         out  1              sticky: rvalid received with FIFO empty
// BEHAVIOUR
//  Reset: rr_ptr=0, lock=0, FIFO empty, err_o=0, outstanding_o=0; all outputs 0 while ch_req_i=0.
//  Selection:
//   - lock=0: winner = first set ch_req_i bit searching from rr_ptr upward, modulo N_CH.
//   - lock=1: winner = locked_id.
//  Issue: lint_req_o = (lock | |ch_req_i) & ~fifo_full. lint_we/addr/wdata/be = winner's fields.
//  Grant: ch_gnt_o[winner] = lint_gnt_i & lint_req_o, combinational, zero latency; other bits 0.
//  Lock:
//   - Set when lint_req_o=1 and lint_gnt_i=0: captures locked_id=winner.
//   - Cleared on the granting cycle.
//   - A locked channel keeps its request and fields stable, per LINT rules.
//  On grant: push winner id to FIFO; rr_ptr <= (winner+1) mod N_CH.
//  Response: when lint_rvalid_i=1, pop the FIFO head, assert ch_rvalid_o[head], ch_rdata_o=lint_rdata_i.
//   Same cycle as lint_rvalid_i, combinational; ch_rvalid_o=0 otherwise.
//  Full: lint_req_o=0 and no grants while occupancy==MAX_OUT.
//   Full and lint_rvalid_i in the same cycle: still stalled this cycle. fifo_full is registered occupancy; no bypass.
//  Simultaneous push and pop when not full: occupancy unchanged; head/tail pointers wrap mod MAX_OUT.
//  Empty and lint_rvalid_i=1: response dropped, ch_rvalid_o=0, err_o<=1 (sticky until reset).
//  Mid-operation reset: FIFO and lock cleared immediately. Late responses fall under the empty rule.
//  Single requester: granted every cycle the slave grants; no bubble cycles.
// STRUCTURE
//  ID_WD = $clog2(N_CH) and the LINT field-width localparams go in dma_pkg, shared with the channel logic.
//  Sub-module dma_arb_id_fifo: ID_WD-wide x MAX_OUT, push/pop/full/empty/count, async reset.
//  Top level holds the rr_ptr/lock registers, the priority search and the muxes.
// TESTING
//  1 Reset, no reqs -> all outputs 0, outstanding_o=0.
//  2 ch_req_i=4'b1111, gnt always 1, rvalid 1 cycle later -> grant order 0,1,2,3,0...
//    ch_rvalid_o follows the same order, delayed one cycle.
//  3 ch_req_i=4'b0101, gnt low for 3 cycles -> lint_addr_o stays at ch0's address.
//    ch2 rising in between does not steal; grant goes to ch0, then ch2.
//  4 Constant gnt, rvalid withheld -> exactly MAX_OUT=4 grants, then lint_req_o=0.
//    One rvalid -> req reasserts next cycle, count 4->3->4.
//  5 lint_rvalid_i pulse with FIFO empty -> ch_rvalid_o=0, err_o=1 and stays 1.
//  6 rstn_i low with 2 outstanding -> outstanding_o=0; next rvalid sets err_o; rr order restarts at ch0.

Source files
------------

// File: rtl/dma_lint_arbiter_pkg.sv
// dma_pkg: shared LINT field widths, arbiter sizing and channel-id helpers
package dma_pkg;
  localparam int N_CH    = 4;
  localparam int ADDR_WD = 32;
  localparam int DATA_WD = 32;
  localparam int BE_WD   = DATA_WD / 8;
  localparam int MAX_OUT = 4;
  localparam int ID_WD   = $clog2(N_CH);
  localparam int CNT_WD  = $clog2(MAX_OUT) + 1;
  typedef logic [ID_WD-1:0] ch_id_t;
  function automatic ch_id_t next_id(input ch_id_t id);
    return ch_id_t'((int'(id) + 1) % N_CH);
  endfunction
endpackage

// File: rtl/dma_lint_arbiter_if.sv
// dma_lint_arbiter_if: channel-side and shared-side LINT signals of the arbiter
interface dma_lint_arbiter_if;
  import dma_pkg::*;
  logic [N_CH-1:0]         ch_req_i;
  logic [N_CH-1:0]         ch_we_i;
  logic [N_CH*ADDR_WD-1:0] ch_addr_i;
  logic [N_CH*DATA_WD-1:0] ch_wdata_i;
  logic [N_CH*BE_WD-1:0]   ch_be_i;
  logic [N_CH-1:0]         ch_gnt_o;
  logic [N_CH-1:0]         ch_rvalid_o;
  logic [DATA_WD-1:0]      ch_rdata_o;
  logic                    lint_req_o;
  logic                    lint_we_o;
  logic [ADDR_WD-1:0]      lint_addr_o;
  logic [DATA_WD-1:0]      lint_wdata_o;
  logic [BE_WD-1:0]        lint_be_o;
  logic                    lint_gnt_i;
  logic [DATA_WD-1:0]      lint_rdata_i;
  logic                    lint_rvalid_i;
  logic [CNT_WD-1:0]       outstanding_o;
  logic                    err_o;
  modport slave (
    input  ch_req_i, ch_we_i, ch_addr_i, ch_wdata_i, ch_be_i,
           lint_gnt_i, lint_rdata_i, lint_rvalid_i,
    output ch_gnt_o, ch_rvalid_o, ch_rdata_o, lint_req_o, lint_we_o,
           lint_addr_o, lint_wdata_o, lint_be_o, outstanding_o, err_o
  );
  modport master (
    output ch_req_i, ch_we_i, ch_addr_i, ch_wdata_i, ch_be_i,
           lint_gnt_i, lint_rdata_i, lint_rvalid_i,
    input  ch_gnt_o, ch_rvalid_o, ch_rdata_o, lint_req_o, lint_we_o,
           lint_addr_o, lint_wdata_o, lint_be_o, outstanding_o, err_o
  );
endinterface

// File: rtl/dma_arb_id_fifo.sv
// dma_arb_id_fifo: in-order FIFO of granted channel ids, power-of-2 depth
module dma_arb_id_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       push_i,
  input  logic [W-1:0]               din_i,
  input  logic                       pop_i,
  output logic [W-1:0]               dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    if (push_i) mem_d[wr_q] = din_i;
    wr_d  = wr_q + PW'(push_i);
    rd_d  = rd_q + PW'(pop_i);
    cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  assign dout_o  = mem_q[rd_q];
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
endmodule

// File: rtl/dma_lint_arbiter.sv
// dma_lint_arbiter: round-robin merge of channel LINT ports onto one shared port
module dma_lint_arbiter
  import dma_pkg::*;
(
  input logic              clk_i,
  input logic              rstn_i,
  dma_lint_arbiter_if.slave bus
);
  ch_id_t            rr_ptr_q, rr_ptr_d, locked_id_q, locked_id_d, win, head, idx;
  logic              lock_q, lock_d, err_q, err_d, push, pop, full, empty, found;
  logic [CNT_WD-1:0] count;
  dma_arb_id_fifo #(.W(ID_WD), .DEPTH(MAX_OUT)) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (push),
    .din_i   (win),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );
  always_comb begin
    win   = rr_ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = ch_id_t'((int'(rr_ptr_q) + i) % N_CH);
      if (!found && bus.ch_req_i[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    if (lock_q) win = locked_id_q;
  end
  // fields are zeroed whenever no request is presented on the shared port
  always_comb begin
    bus.lint_req_o   = (lock_q | (|bus.ch_req_i)) & ~full;
    bus.lint_we_o    = bus.lint_req_o & bus.ch_we_i[win];
    bus.lint_addr_o  = bus.lint_req_o ? bus.ch_addr_i[int'(win)*ADDR_WD +: ADDR_WD] : '0;
    bus.lint_wdata_o = bus.lint_req_o ? bus.ch_wdata_i[int'(win)*DATA_WD +: DATA_WD] : '0;
    bus.lint_be_o    = bus.lint_req_o ? bus.ch_be_i[int'(win)*BE_WD +: BE_WD] : '0;
    push             = bus.lint_req_o & bus.lint_gnt_i;
    pop              = bus.lint_rvalid_i & ~empty;
    bus.ch_gnt_o     = push ? N_CH'(1) << win : '0;
    bus.ch_rvalid_o  = pop ? N_CH'(1) << head : '0;
    bus.ch_rdata_o   = pop ? bus.lint_rdata_i : '0;
    bus.outstanding_o = count;
    bus.err_o        = err_q;
  end
  always_comb begin
    lock_d      = push ? 1'b0 : (bus.lint_req_o ? 1'b1 : lock_q);
    locked_id_d = (bus.lint_req_o & ~bus.lint_gnt_i) ? win : locked_id_q;
    rr_ptr_d    = push ? next_id(win) : rr_ptr_q;
    err_d       = err_q | (bus.lint_rvalid_i & empty);
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      rr_ptr_q    <= '0;
      locked_id_q <= '0;
      lock_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      locked_id_q <= locked_id_d;
      lock_q      <= lock_d;
      err_q       <= err_d;
    end
endmodule

// File: tb/tb_dma_lint_arbiter.sv
// tb_dma_lint_arbiter: directed scenarios plus random traffic against a queue-based model
module tb_dma_lint_arbiter;
  import dma_pkg::*;
  logic clk_i = 1'b0;
  logic rstn_i = 1'b0;
  dma_lint_arbiter_if bus();
  dma_lint_arbiter dut (.clk_i(clk_i), .rstn_i(rstn_i), .bus(bus));
  always #5 clk_i = ~clk_i;
  int total = 0;
  int bad = 0;
  int m_rr, m_lid;
  bit m_lock, m_err;
  int q[$];
  int s_gid, s_rid, s_out;
  bit s_req;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic eval();
    int win;
    bit req, grant, pop, was_empty;
    logic [N_CH-1:0] eg, er;
    #1;
    if (!rstn_i) begin
      q.delete();
      m_lock = 0; m_rr = 0; m_err = 0;
    end
    win = m_lock ? m_lid : -1;
    if (!m_lock)
      for (int k = 0; k < N_CH; k++)
        if (win < 0 && bus.ch_req_i[(m_rr + k) % N_CH]) win = (m_rr + k) % N_CH;
    req = (m_lock || bus.ch_req_i != '0) && q.size() < MAX_OUT;
    grant = req && bus.lint_gnt_i;
    was_empty = q.size() == 0;
    pop = bus.lint_rvalid_i && !was_empty;
    eg = '0; if (grant) eg[win] = 1'b1;
    er = '0; if (pop) er[q[0]] = 1'b1;
    chk("lint_req", 64'(bus.lint_req_o), 64'(req));
    chk("ch_gnt", 64'(bus.ch_gnt_o), 64'(eg));
    chk("ch_rvalid", 64'(bus.ch_rvalid_o), 64'(er));
    chk("outstanding", 64'(bus.outstanding_o), 64'(q.size()));
    chk("err", 64'(bus.err_o), 64'(m_err));
    if (req) begin
      chk("lint_we", 64'(bus.lint_we_o), 64'(bus.ch_we_i[win]));
      chk("lint_addr", 64'(bus.lint_addr_o), 64'(bus.ch_addr_i[win*ADDR_WD +: ADDR_WD]));
      chk("lint_wdata", 64'(bus.lint_wdata_o), 64'(bus.ch_wdata_i[win*DATA_WD +: DATA_WD]));
      chk("lint_be", 64'(bus.lint_be_o), 64'(bus.ch_be_i[win*BE_WD +: BE_WD]));
    end else if (!m_lock && bus.ch_req_i == '0) begin
      chk("idle_addr", 64'(bus.lint_addr_o), 64'h0);
      chk("idle_we", 64'(bus.lint_we_o), 64'h0);
    end
    if (pop) chk("ch_rdata", 64'(bus.ch_rdata_o), 64'(bus.lint_rdata_i));
    s_req = bus.lint_req_o;
    s_out = int'(bus.outstanding_o);
    s_gid = -1; s_rid = -1;
    for (int k = 0; k < N_CH; k++) begin
      if (bus.ch_gnt_o[k]) s_gid = k;
      if (bus.ch_rvalid_o[k]) s_rid = k;
    end
    if (rstn_i) begin
      if (pop) void'(q.pop_front());
      if (grant) begin
        q.push_back(win);
        m_rr = (win + 1) % N_CH;
        m_lock = 0;
      end else if (req) begin
        m_lock = 1;
        m_lid = win;
      end
      if (bus.lint_rvalid_i && was_empty) m_err = 1;
    end
    @(negedge clk_i);
  endtask
  task automatic set_in(input logic [N_CH-1:0] r, input logic g, input logic v);
    bus.ch_req_i = r;
    bus.lint_gnt_i = g;
    bus.lint_rvalid_i = v;
    bus.lint_rdata_i = $urandom();
  endtask
  task automatic drive_rand();
    for (int k = 0; k < N_CH; k++) begin
      if (!(m_lock && k == m_lid)) begin
        bus.ch_req_i[k] = 1'($urandom_range(0, 1));
        bus.ch_we_i[k] = 1'($urandom_range(0, 1));
        bus.ch_addr_i[k*ADDR_WD +: ADDR_WD] = $urandom();
        bus.ch_wdata_i[k*DATA_WD +: DATA_WD] = $urandom();
        bus.ch_be_i[k*BE_WD +: BE_WD] = BE_WD'($urandom());
      end
    end
    bus.lint_gnt_i = $urandom_range(0, 9) < 6;
    bus.lint_rvalid_i = q.size() > 0 ? $urandom_range(0, 1) == 1 : $urandom_range(0, 29) == 0;
    bus.lint_rdata_i = $urandom();
    rstn_i = $urandom_range(0, 399) != 0;
  endtask
  initial begin
    int n;
    for (int k = 0; k < N_CH; k++) begin
      bus.ch_addr_i[k*ADDR_WD +: ADDR_WD] = 32'h1000 + 32'(k) * 32'h100;
      bus.ch_wdata_i[k*DATA_WD +: DATA_WD] = 32'hA000_0000 + 32'(k);
      bus.ch_be_i[k*BE_WD +: BE_WD] = BE_WD'(k + 1);
    end
    bus.ch_we_i = 4'b0101;
    set_in('0, 1'b0, 1'b0);
    @(negedge clk_i);
    eval(); eval();
    chk("t1_rst_req", 64'(bus.lint_req_o), 64'h0);
    chk("t1_rst_out", 64'(bus.outstanding_o), 64'h0);
    rstn_i = 1'b1;
    eval();
    chk("t1_gnt", 64'(bus.ch_gnt_o), 64'h0);
    chk("t1_addr", 64'(bus.lint_addr_o), 64'h0);
    chk("t1_err", 64'(bus.err_o), 64'h0);
    set_in(4'b1111, 1'b1, 1'b0);
    eval();
    chk("t2_gnt0", 64'(s_gid), 64'h0);
    bus.lint_rvalid_i = 1'b1;
    for (int i = 1; i < 8; i++) begin
      bus.lint_rdata_i = $urandom();
      eval();
      chk("t2_gnt_order", 64'(s_gid), 64'(i % 4));
      chk("t2_rv_order", 64'(s_rid), 64'((i - 1) % 4));
    end
    set_in('0, 1'b0, 1'b1);
    eval();
    chk("t2_rv_last", 64'(s_rid), 64'h3);
    set_in(4'b0001, 1'b0, 1'b0);
    eval();
    chk("t3_addr_a", 64'(bus.lint_addr_o), 64'h1000);
    bus.ch_req_i = 4'b0101;
    eval();
    chk("t3_addr_b", 64'(bus.lint_addr_o), 64'h1000);
    eval();
    chk("t3_addr_c", 64'(bus.lint_addr_o), 64'h1000);
    bus.lint_gnt_i = 1'b1;
    eval();
    chk("t3_gnt_ch0", 64'(s_gid), 64'h0);
    bus.ch_req_i = 4'b0100;
    eval();
    chk("t3_gnt_ch2", 64'(s_gid), 64'h2);
    set_in('0, 1'b0, 1'b1);
    eval();
    chk("t3_rv_ch0", 64'(s_rid), 64'h0);
    eval();
    chk("t3_rv_ch2", 64'(s_rid), 64'h2);
    set_in(4'b1111, 1'b1, 1'b0);
    n = 0;
    repeat (6) begin
      eval();
      if (s_gid >= 0) n++;
    end
    chk("t4_grants", 64'(n), 64'h4);
    chk("t4_full_req", 64'(s_req), 64'h0);
    chk("t4_full_cnt", 64'(bus.outstanding_o), 64'h4);
    bus.lint_rvalid_i = 1'b1;
    eval();
    chk("t4_stall_req", 64'(s_req), 64'h0);
    chk("t4_stall_rv", 64'(s_rid), 64'h3);
    bus.lint_rvalid_i = 1'b0;
    eval();
    chk("t4_cnt3", 64'(s_out), 64'h3);
    chk("t4_rereq", 64'(s_req), 64'h1);
    eval();
    chk("t4_cnt4", 64'(s_out), 64'h4);
    set_in('0, 1'b0, 1'b1);
    repeat (4) eval();
    bus.lint_rvalid_i = 1'b0;
    eval();
    chk("t4_drained", 64'(bus.outstanding_o), 64'h0);
    chk("t5_err_pre", 64'(bus.err_o), 64'h0);
    bus.lint_rvalid_i = 1'b1;
    eval();
    chk("t5_drop", 64'(s_rid), 64'hffff_ffff_ffff_ffff);
    chk("t5_err_set", 64'(bus.err_o), 64'h1);
    bus.lint_rvalid_i = 1'b0;
    repeat (3) eval();
    chk("t5_err_sticky", 64'(bus.err_o), 64'h1);
    set_in(4'b1111, 1'b1, 1'b0);
    eval(); eval();
    chk("t6_pre_out", 64'(bus.outstanding_o), 64'h2);
    set_in('0, 1'b0, 1'b0);
    rstn_i = 1'b0;
    eval();
    chk("t6_rst_out", 64'(bus.outstanding_o), 64'h0);
    chk("t6_rst_err", 64'(bus.err_o), 64'h0);
    rstn_i = 1'b1;
    bus.lint_rvalid_i = 1'b1;
    eval();
    chk("t6_late_err", 64'(bus.err_o), 64'h1);
    set_in(4'b1111, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      eval();
      chk("t6_rr_restart", 64'(s_gid), 64'(i));
    end
    repeat (3000) begin
      drive_rand();
      eval();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
